// File: rtl/floating_point_to_int.sv
// Float-to-signed-integer converter: round-to-nearest-even, saturating,
// fully pipelined with a fixed 5-cycle latency and no backpressure.
module floating_point_to_int #(
    parameter int unsigned FRAC_WIDTH = 24,
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned INT_WIDTH  = 32
) (
    input  logic                              clkIn,
    input  logic                              rstIn,
    input  logic [FRAC_WIDTH+EXP_WIDTH-1:0]   dataIn,
    input  logic                              validIn,
    output logic [INT_WIDTH-1:0]              dataOut,
    output logic                              validOut,
    output logic                              invalidOut,
    output logic                              overflowOut
);

    localparam int unsigned DATA_WIDTH = FRAC_WIDTH + EXP_WIDTH;
    localparam int unsigned MAN_W      = FRAC_WIDTH - 1;
    localparam int unsigned E_W        = EXP_WIDTH + 2;
    localparam int unsigned SH_W       = $clog2(FRAC_WIDTH + INT_WIDTH + 1);
    localparam int unsigned STAGES     = 5;
    localparam int unsigned BIAS       = (2 ** (EXP_WIDTH - 1)) - 1;

    localparam logic signed [E_W-1:0] E_BIAS = E_W'(BIAS);
    localparam logic signed [E_W-1:0] E_NEG1 = E_W'(-1);
    localparam logic signed [E_W-1:0] E_LSH  = E_W'(FRAC_WIDTH - 1);
    localparam logic signed [E_W-1:0] E_BIG  = E_W'(INT_WIDTH - 1);

    localparam logic [INT_WIDTH-1:0] INT_MIN = {1'b1, {(INT_WIDTH-1){1'b0}}};
    localparam logic [INT_WIDTH-1:0] INT_MAX = {1'b0, {(INT_WIDTH-1){1'b1}}};

    typedef struct packed {
        logic sign;
        logic nan;
        logic inf;
        logic tiny;       // magnitude below 0.5 or exp == 0: result is 0
        logic big;        // e >= INT_WIDTH-1: out of range before shifting
        logic exact_min;  // exactly -2^(INT_WIDTH-1), representable
    } cls_t;

    // Valid shift register, independent of the data path
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;

    // Stage 1: decode and classify
    logic [EXP_WIDTH-1:0]    exp_c;
    logic [MAN_W-1:0]        man_c;
    logic signed [E_W-1:0]   e_c;
    cls_t                    cls1_d, cls1_q;
    logic [MAN_W-1:0]        man1_q;
    logic                    lsh1_d, lsh1_q;
    logic [SH_W-1:0]         shamt1_d, shamt1_q;

    // Stage 2: align significand, keep guard/sticky
    logic [FRAC_WIDTH-1:0]   sig_c;
    logic [2*FRAC_WIDTH-1:0] ext_c;
    logic [INT_WIDTH-1:0]    mag2_d, mag2_q;
    logic                    guard2_d, guard2_q;
    logic                    sticky2_d, sticky2_q;
    cls_t                    cls2_q;

    // Stage 3: round to nearest even
    logic                    rnd_c;
    logic [INT_WIDTH-1:0]    mag3_d, mag3_q;
    cls_t                    cls3_q;

    // Stage 4: sign, saturation and special values
    logic [INT_WIDTH-1:0]    res4_d, res4_q;
    logic                    inv4_d, inv4_q;
    logic                    ovf4_d, ovf4_q;

    // Stage 5: output registers
    logic [INT_WIDTH-1:0]    data_out_q;
    logic                    invalid_q;
    logic                    overflow_q;

    assign valid_d = {valid_q[STAGES-2:0], validIn};

    always_comb begin
        exp_c  = dataIn[DATA_WIDTH-2 -: EXP_WIDTH];
        man_c  = dataIn[MAN_W-1:0];
        e_c    = $signed({2'b00, exp_c}) - E_BIAS;
        cls1_d = '0;
        cls1_d.sign      = dataIn[DATA_WIDTH-1];
        cls1_d.nan       = (&exp_c) && (|man_c);
        cls1_d.inf       = (&exp_c) && !(|man_c);
        cls1_d.tiny      = (exp_c == '0) || (e_c < E_NEG1);
        cls1_d.big       = (e_c >= E_BIG);
        cls1_d.exact_min = dataIn[DATA_WIDTH-1] && !(|man_c) && (e_c == E_BIG);
        lsh1_d   = (e_c >= E_LSH);
        shamt1_d = lsh1_d ? SH_W'(e_c - E_LSH) : SH_W'(E_LSH - e_c);
    end

    // Right shifts move the significand into a fractional half of equal width,
    // so no bit is ever lost before guard/sticky are extracted.
    always_comb begin
        sig_c     = {1'b1, man1_q};
        ext_c     = {sig_c, {FRAC_WIDTH{1'b0}}} >> shamt1_q;
        mag2_d    = lsh1_q ? (INT_WIDTH'(sig_c) << shamt1_q)
                           : INT_WIDTH'(ext_c[2*FRAC_WIDTH-1:FRAC_WIDTH]);
        guard2_d  = !lsh1_q && ext_c[FRAC_WIDTH-1];
        sticky2_d = !lsh1_q && (|ext_c[FRAC_WIDTH-2:0]);
    end

    always_comb begin
        rnd_c  = guard2_q && (sticky2_q || mag2_q[0]);
        mag3_d = mag2_q + INT_WIDTH'(rnd_c);
    end

    always_comb begin
        res4_d = '0;
        inv4_d = 1'b0;
        ovf4_d = 1'b0;
        if (cls3_q.nan) begin
            res4_d = INT_MIN;
            inv4_d = 1'b1;
        end else if (cls3_q.inf) begin
            res4_d = cls3_q.sign ? INT_MIN : INT_MAX;
            ovf4_d = 1'b1;
        end else if (!cls3_q.tiny) begin
            if (cls3_q.big) begin
                if (cls3_q.exact_min) begin
                    res4_d = INT_MIN;
                end else begin
                    res4_d = cls3_q.sign ? INT_MIN : INT_MAX;
                    ovf4_d = 1'b1;
                end
            end else if (mag3_q[INT_WIDTH-1]) begin
                // Rounding reached 2^(INT_WIDTH-1): only the negative side fits
                res4_d = cls3_q.sign ? INT_MIN : INT_MAX;
                ovf4_d = !cls3_q.sign;
            end else begin
                res4_d = cls3_q.sign ? (INT_WIDTH'(0) - mag3_q) : mag3_q;
            end
        end
    end

    // Data path registers need no reset; results are qualified by validOut
    always_ff @(posedge clkIn) begin
        cls1_q    <= cls1_d;
        man1_q    <= man_c;
        lsh1_q    <= lsh1_d;
        shamt1_q  <= shamt1_d;
        mag2_q    <= mag2_d;
        guard2_q  <= guard2_d;
        sticky2_q <= sticky2_d;
        cls2_q    <= cls1_q;
        mag3_q    <= mag3_d;
        cls3_q    <= cls2_q;
        res4_q    <= res4_d;
        inv4_q    <= inv4_d;
        ovf4_q    <= ovf4_d;
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            valid_q    <= '0;
            data_out_q <= '0;
            invalid_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            data_out_q <= res4_q;
            invalid_q  <= inv4_q;
            overflow_q <= ovf4_q;
        end
    end

    assign dataOut     = data_out_q;
    assign validOut    = valid_q[STAGES-1];
    assign invalidOut  = invalid_q;
    assign overflowOut = overflow_q;

endmodule

// File: doc/floating_point_to_int.md
FLOATING_POINT_TO_INT -- requirements
Module: floating_point_to_int

Interface
REQ-001 SHALL have parameter FRAC_WIDTH, default 24, meaning significand width including the implicit bit.
REQ-002 SHALL have parameter EXP_WIDTH, default 8, meaning exponent field width; float width DATA_WIDTH = FRAC_WIDTH + EXP_WIDTH.
REQ-003 SHALL have parameter INT_WIDTH, default 32, meaning width of the signed two's-complement result.
REQ-004 SHALL have port clkIn, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rstIn, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port dataIn, input, DATA_WIDTH, IEEE-style float: {sign, exponent, mantissa}.
REQ-007 SHALL have port validIn, input, 1, qualifies dataIn on the current cycle.
REQ-008 SHALL have port dataOut, output, INT_WIDTH, signed integer result.
REQ-009 SHALL have port validOut, output, 1, qualifies dataOut, invalidOut and overflowOut.
REQ-010 SHALL have port invalidOut, output, 1, high when the input was NaN.
REQ-011 SHALL have port overflowOut, output, 1, high when the input was Inf or the rounded value was out of INT_WIDTH range.

Function
REQ-012 SHALL be fully pipelined with fixed latency 5: a sample with validIn high at edge N appears with validOut high after edge N+5.
REQ-013 SHALL accept one sample per cycle with no stall or backpressure; back-to-back samples emerge back-to-back, in order.
REQ-014 SHALL carry validIn through a 5-stage shift register independent of the data path.
REQ-015 SHALL produce dataOut, invalidOut and overflowOut regardless of validIn; consumers qualify them with validOut.
REQ-016 SHALL use bias 2^(EXP_WIDTH-1)-1 (127) and unbiased exponent e = exp - bias.
REQ-017 SHALL treat exp == 0, including zero and subnormals, as magnitude below 0.5, so the result is 0 with no flags.
REQ-018 SHALL form the magnitude as {1, mantissa} scaled by 2^(e-(FRAC_WIDTH-1)), keeping guard and sticky bits for right shifts.
REQ-019 SHALL return 0 with no flags when e < -1; e = -1 goes through normal rounding.
REQ-020 SHALL round to nearest with ties to even: round bit = guard AND (sticky OR LSB).
REQ-021 SHALL apply the sign after rounding by two's-complement negation of the rounded magnitude.
REQ-022 SHALL saturate a positive rounded magnitude >= 2^(INT_WIDTH-1) to 0x7FFFFFFF with overflowOut = 1.
REQ-023 SHALL pass a negative rounded magnitude of exactly 2^(INT_WIDTH-1) as 0x80000000 with overflowOut = 0.
REQ-024 SHALL saturate a negative rounded magnitude above 2^(INT_WIDTH-1) to 0x80000000 with overflowOut = 1.
REQ-025 SHALL detect overflow from e >= INT_WIDTH-1 before shifting, so the left shift never exceeds INT_WIDTH bits, and also when rounding carries out.
REQ-026 SHALL output Inf (exp all ones, mantissa 0) as 0x7FFFFFFF for sign 0 or 0x80000000 for sign 1, with overflowOut = 1.
REQ-027 SHALL output NaN (exp all ones, mantissa != 0) as 0x80000000 with invalidOut = 1 and overflowOut = 0; the NaN check takes priority over the Inf check.
REQ-028 SHALL output 0 for -0.0 (0x80000000 input), i.e. 0x00000000 with no flags.

Reset
REQ-029 SHALL clear all 5 valid-pipeline stages, dataOut, invalidOut and overflowOut to 0 on the first rising edge with rstIn high.
REQ-030 SHALL drop any samples in flight when reset is asserted mid-operation, with validOut low from the edge after reset is first sampled high.
REQ-031 SHALL ignore validIn samples taken while rstIn is high; those samples never produce validOut.
REQ-032 SHALL accept a sample presented on the first edge with rstIn low, and return it 5 cycles later.

Verification
REQ-033 Basic and ties: 0x3F800000 (1.0) -> 0x00000001; 0x40200000 (2.5) -> 0x00000002; 0x40600000 (3.5) -> 0x00000004; 0x3F000000 (0.5) -> 0x00000000; no flags, each at latency 5.
REQ-034 Negative: 0xBFC00000 (-1.5) -> 0xFFFFFFFE; 0xCF000000 (-2^31) -> 0x80000000 with overflowOut = 0.
REQ-035 Saturation: 0x4F32D05E (3e9) -> 0x7FFFFFFF with overflowOut = 1; 0xFF800000 (-Inf) -> 0x80000000 with overflowOut = 1.
REQ-036 NaN and subnormal: 0x7FC00000 -> 0x80000000 with invalidOut = 1; 0x00000001 -> 0x00000000 with no flags.
REQ-037 Throughput: 20 consecutive valid random floats produce 20 consecutive validOut cycles, in order, matching the reference model bit-exactly.
REQ-038 Reset mid-stream: rstIn high for 1 cycle while 3 samples are in flight -> those samples never appear with validOut high, and a sample presented after reset returns correctly 5 cycles later.
